// File: rtl/serial_twos_comp_nch_if.sv
// Bit-serial lane bundle for serial_twos_comp_nch: shared framing/qualifier plus N data lanes.
// The master side feeds serial words in and the slave side returns the results.
interface serial_twos_comp_nch_if #(
   parameter int N = 1
);
   logic         i_valid;
   logic         i_sof;
   logic [N-1:0] i;
   logic [N-1:0] neg;
   logic [N-1:0] y;
   logic         y_valid;
   logic         y_eow;
   logic [N-1:0] ovf;

   modport master (
      output i_valid, i_sof, i, neg,
      input  y, y_valid, y_eow, ovf
   );

   modport slave (
      input  i_valid, i_sof, i, neg,
      output y, y_valid, y_eow, ovf
   );
endinterface

// File: rtl/serial_twos_comp_nch.sv
// N-lane bit-serial (LSB-first) two's-complement negator with a shared word counter.
// Define SERCOMP_OVF_EN to build in per-lane overflow detection; otherwise ovf is tied to 0.
module serial_twos_comp_nch #(
   parameter int W = 8,
   parameter int N = 1
) (
   input logic                  t_clk,
   input logic                  r_n,
   serial_twos_comp_nch_if.slave bus
);
   localparam int             CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0]  LAST = CW'(W - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] idx_p0;
   logic          bit0_p0;
   logic          last_p0;
   logic [N-1:0]  mode;
   logic [N-1:0]  seen;
   logic [N-1:0]  mode_p0;
   logic [N-1:0]  seen_p0;
   logic [N-1:0]  y_p0;
   logic [N-1:0]  y_p1;
   logic          vld_p1;
   logic          eow_p1;

   // Stage p0: an i_sof forces bit 0, which also restarts framing after an aborted word.
   always_comb begin
      idx_p0  = (bus.i_valid && bus.i_sof) ? '0 : cnt;
      bit0_p0 = (idx_p0 == '0);
      last_p0 = (idx_p0 == LAST);
      mode_p0 = bit0_p0 ? bus.neg : mode;
      seen_p0 = bit0_p0 ? '0 : seen;
      // Negation flips every bit above the lowest set bit.
      y_p0    = bus.i ^ (mode_p0 & seen_p0);
   end

   // Stage p1: registered outputs; y holds across invalid cycles.
   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) begin
         cnt    <= '0;
         mode   <= '0;
         seen   <= '0;
         y_p1   <= '0;
         vld_p1 <= 1'b0;
         eow_p1 <= 1'b0;
      end else begin
         vld_p1 <= bus.i_valid;
         eow_p1 <= bus.i_valid && last_p0;
         if (bus.i_valid) begin
            cnt  <= last_p0 ? '0 : idx_p0 + CW'(1);
            mode <= mode_p0;
            seen <= seen_p0 | bus.i;
            y_p1 <= y_p0;
         end
      end
   end

   assign bus.y       = y_p1;
   assign bus.y_valid = vld_p1;
   assign bus.y_eow   = eow_p1;

`ifdef SERCOMP_OVF_EN
   logic [N-1:0] ovf_p0;
   logic [N-1:0] ovf_p1;

   // Only -2^(W-1) reaches the sign bit with no lower bit set; its negation wraps.
   assign ovf_p0 = (bus.i_valid && last_p0) ? (mode_p0 & bus.i & ~seen_p0) : '0;

   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) ovf_p1 <= '0;
      else      ovf_p1 <= ovf_p0;
   end

   assign bus.ovf = ovf_p1;
`else
   assign bus.ovf = '0;
`endif
endmodule
